tx_scheduler: RTL and testbench

Shares the half-duplex optical transceiver TX path between two requesters: the (N)ACK responder (priority) and the normal message sender. It grants access only after the light channel has been quiet for a programmable gap, holds the grant until the transceiver reports frame completion, and bounds priority starvation of normal traffic. It also enforces a watchdog so that a lost completion cannot lock the link. It sits between the TX/RX control FSMs and the transceiver `tx_enable` path.

---
 rtl/tx_scheduler.sv | 132 +++++++++++++
 tb/tb_tx_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_scheduler.sv
// tx_scheduler
//   Arbitrates the half-duplex optical TX path between the (N)ACK responder
//   (priority) and the normal message sender. A grant is issued only after the
//   line has been quiet for IDLE_GAP cycles. It is held until tx_done, until the
//   owner withdraws its request, or until the watchdog expires. Consecutive
//   contested priority wins are capped by STARVE_LIMIT. One HOLDOFF cycle
//   separates successive grants.
//
// Ports
//   clock          in   system clock
//   reset          in   synchronous, active-high reset
//   req_priority   in   level request from the (N)ACK path
//   req_normal     in   level request from the normal message path
//   tx_done        in   one-cycle frame completion pulse from the transceiver
//   line_busy      in   synchronised receive activity
//   grant_priority out  priority requester owns the TX path
//   grant_normal   out  normal requester owns the TX path
//   busy           out  high in every state except IDLE
//   grant_timeout  out  one-cycle pulse in the release cycle after watchdog expiry
module tx_scheduler #(
    parameter int IDLE_GAP     = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_GRANT    = 4096
) (
    input  logic clock,
    input  logic reset,
    input  logic req_priority,
    input  logic req_normal,
    input  logic tx_done,
    input  logic line_busy,
    output logic grant_priority,
    output logic grant_normal,
    output logic busy,
    output logic grant_timeout
);

    localparam logic [7:0]  GAP   = 8'(IDLE_GAP);
    localparam logic [3:0]  LIMIT = 4'(STARVE_LIMIT);
    localparam logic [15:0] WD_LD = 16'(MAX_GRANT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_P = 2'd1,
        GRANT_N = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  idle_cnt;
    logic [3:0]  streak;
    logic [15:0] watchdog;

    logic in_grant;
    logic owner_req;
    logic granting;
    logic pick_normal;
    logic release_grant;
    logic expire;

    assign in_grant  = (state == GRANT_P) || (state == GRANT_N);
    assign owner_req = (state == GRANT_P) ? req_priority : req_normal;

    // Normal wins when it is alone, or when priority has already won
    // STARVE_LIMIT contested rounds in a row.
    assign granting    = (state == IDLE) && (idle_cnt == GAP) && (req_priority || req_normal);
    assign pick_normal = req_normal && (!req_priority || (streak >= LIMIT));

    // tx_done takes precedence: a timeout is only flagged when no completion
    // arrives in the expiry cycle.
    assign release_grant = in_grant && (tx_done || !owner_req || (watchdog == 16'd0));
    assign expire        = in_grant && (watchdog == 16'd0) && !tx_done;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (granting) state_next = pick_normal ? GRANT_N : GRANT_P;
            GRANT_P,
            GRANT_N: if (release_grant) state_next = HOLDOFF;
            HOLDOFF: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        grant_priority = (state == GRANT_P);
        grant_normal   = (state == GRANT_N);
        busy           = (state != IDLE);
    end

    // Quiet-line counter. Frozen while granted so our own TX echo on the
    // receiver is not mistaken for foreign traffic; restarted on release so the
    // full gap is enforced between frames.
    always_ff @(posedge clock) begin
        if (reset)                  idle_cnt <= 8'd0;
        else if (release_grant)     idle_cnt <= 8'd0;
        else if (in_grant)          idle_cnt <= idle_cnt;
        else if (line_busy)         idle_cnt <= 8'd0;
        else if (idle_cnt != GAP)   idle_cnt <= idle_cnt + 8'd1;
    end

    // Starvation streak: counts only contested priority wins.
    always_ff @(posedge clock) begin
        if (reset)                    streak <= 4'd0;
        else if (!req_normal)         streak <= 4'd0;
        else if (granting) begin
            if (pick_normal)          streak <= 4'd0;
            else                      streak <= streak + 4'd1;
        end
    end

    // Watchdog: loaded on grant, counts down while granted.
    always_ff @(posedge clock) begin
        if (reset)                              watchdog <= 16'd0;
        else if (granting)                      watchdog <= WD_LD;
        else if (in_grant && watchdog != 16'd0) watchdog <= watchdog - 16'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) grant_timeout <= 1'b0;
        else       grant_timeout <= expire;
    end

endmodule

// File: tb/tb_tx_scheduler.sv
module tb_tx_scheduler;

    localparam int GAP = 4;
    localparam int SL  = 2;
    localparam int MG  = 8;

    logic clock;
    logic reset;
    logic rp, rn, td, lb;
    logic gp, gn, bz, gt;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    // Reference model: owner (0 none, 1 priority, 2 normal), holdoff flag,
    // length of the current quiet run, age of current grant, contested streak.
    int m_owner = 0;
    bit m_hold  = 0;
    int m_quiet = 0;
    int m_age   = 0;
    int m_streak = 0;
    bit m_to    = 0;

    tx_scheduler #(.IDLE_GAP(GAP), .STARVE_LIMIT(SL), .MAX_GRANT(MG)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_priority   (rp),
        .req_normal     (rn),
        .tx_done        (td),
        .line_busy      (lb),
        .grant_priority (gp),
        .grant_normal   (gn),
        .busy           (bz),
        .grant_timeout  (gt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic obs, input logic exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // Advance the model with the inputs currently applied, clock the DUT, then
    // compare every output one time unit after the edge.
    task automatic tick();
        int w;
        bit rel;
        bit to;
        to = 0;
        if (reset) begin
            m_owner = 0; m_hold = 0; m_quiet = 0; m_age = 0; m_streak = 0;
        end else if (m_owner != 0) begin
            rel = td || !(m_owner == 1 ? rp : rn) || (m_age == MG - 1);
            if (rel) begin
                to = !td && (m_age == MG - 1);
                m_owner = 0; m_hold = 1; m_quiet = 0;
            end else begin
                m_age++;
            end
            if (!rn) m_streak = 0;
        end else begin
            w = 0;
            if (!m_hold && m_quiet == GAP && (rp || rn))
                w = (rn && (!rp || m_streak == SL)) ? 2 : 1;
            if (!rn || w == 2) m_streak = 0;
            else if (w == 1)   m_streak++;
            m_quiet = lb ? 0 : ((m_quiet < GAP) ? m_quiet + 1 : GAP);
            m_hold = 0;
            if (w != 0) begin m_owner = w; m_age = 0; end
        end
        m_to = to;
        @(posedge clock);
        #1;
        cyc++;
        chk("grant_priority", gp, m_owner == 1);
        chk("grant_normal",   gn, m_owner == 2);
        chk("busy",           bz, (m_owner != 0) || m_hold);
        chk("grant_timeout",  gt, m_to);
        chk("grants_exclusive", gp & gn, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1; rp = 0; rn = 0; td = 0; lb = 0;
        tick();
        tick();
        chk("reset_busy", bz, 1'b0);
        reset = 0;
        cyc = 0;
    endtask

    task automatic wait_grant(input bit want_p, input int limit, input string tag);
        int n;
        n = 0;
        while (!(want_p ? gp : gn) && n < limit) begin
            tick();
            n++;
        end
        chk(tag, want_p ? gp : gn, 1'b1);
    endtask

    initial begin
        int hc;
        int b;
        int d;
        int seq[$];
        int exp_seq[6];
        bit prev;

        reset = 1; rp = 0; rn = 0; td = 0; lb = 0;
        @(posedge clock);
        #1;

        // Latency from reset, release, back-to-back spacing
        do_reset();
        rn = 1;
        for (int i = 0; i < 28; i++) begin
            td = (cyc == 20);
            tick();
            if (cyc == 4)  chk("t1_no_grant_c4", gn, 1'b0);
            if (cyc == 5)  chk("t1_grant_c5", gn, 1'b1);
            if (cyc == 21) chk("t1_release_c21", gn, 1'b0);
            if (cyc == 21) chk("t1_holdoff_busy", bz, 1'b1);
            if (cyc == 22) chk("t1_idle_c22", bz, 1'b0);
            if (cyc == 25) chk("t1_no_grant_c25", gn, 1'b0);
            if (cyc == 26) chk("t1_regrant_c26", gn, 1'b1);
        end
        td = 0; rn = 0;
        tick(); tick();

        // Starvation bound: P, P, N, P, P, N
        do_reset();
        rp = 1; rn = 1;
        hc = 0; prev = 0;
        for (int i = 0; i < 200 && seq.size() < 6; i++) begin
            td = (gp || gn) && (hc == 3);
            tick();
            if ((gp || gn) && !prev) begin
                seq.push_back(gp ? 1 : 2);
                hc = 1;
            end else if (gp || gn) begin
                hc++;
            end else begin
                hc = 0;
            end
            prev = gp || gn;
        end
        td = 0;
        exp_seq = '{1, 1, 2, 1, 1, 2};
        chk_int("t2_grant_count", seq.size(), 6);
        for (int i = 0; i < seq.size() && i < 6; i++)
            chk_int("t2_grant_order", seq[i], exp_seq[i]);
        rp = 0; rn = 0;
        tick(); tick();

        // Busy line keeps the gap from ever completing
        do_reset();
        rn = 1;
        b = 0;
        for (int i = 0; i < 30; i++) begin
            lb = (i % 3 == 0);
            if (lb) b = cyc;
            tick();
            chk("t3_no_grant", gn, 1'b0);
        end
        lb = 0;
        for (int i = 0; i < 10 && cyc < b + 6; i++) begin
            tick();
            if (cyc == b + 5) chk("t3_no_grant_before", gn, 1'b0);
            if (cyc == b + 6) chk("t3_grant_after_gap", gn, 1'b1);
        end
        rn = 0;
        tick(); tick();

        // Watchdog expiry, then tx_done on the expiry cycle
        do_reset();
        rp = 1;
        wait_grant(1, 20, "t4_first_grant");
        hc = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gp) hc++;
            else break;
        end
        chk_int("t4_grant_len", hc, MG);
        chk("t4_timeout_pulse", gt, 1'b1);
        tick();
        chk("t4_timeout_one_cycle", gt, 1'b0);
        wait_grant(1, 20, "t4_second_grant");
        for (int i = 0; i < MG - 1; i++) tick();
        td = 1;
        tick();
        td = 0;
        chk("t4_done_release", gp, 1'b0);
        chk("t4_done_no_timeout", gt, 1'b0);
        rp = 0;
        tick(); tick();

        // Priority never preempts a normal grant
        do_reset();
        rn = 1;
        wait_grant(0, 20, "t5_normal_grant");
        tick();
        rp = 1;
        tick();
        chk("t5_no_preempt", gp, 1'b0);
        tick();
        rn = 0;
        d = cyc;
        tick();
        chk("t5_withdraw", gn, 1'b0);
        for (int i = 0; i < 10 && cyc < d + 6; i++) begin
            tick();
            chk("t5_no_timeout", gt, 1'b0);
            if (cyc == d + 5) chk("t5_wait_gap", gp, 1'b0);
            if (cyc == d + 6) chk("t5_priority_served", gp, 1'b1);
        end
        rp = 0;
        tick(); tick();

        // Reset in the middle of a priority grant
        do_reset();
        rp = 1;
        wait_grant(1, 20, "t6_grant");
        tick(); tick();
        reset = 1;
        tick();
        chk("t6_reset_gp", gp, 1'b0);
        chk("t6_reset_busy", bz, 1'b0);
        reset = 0;
        cyc = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (cyc < 5)  chk("t6_no_early_grant", gp, 1'b0);
            if (cyc == 5) chk("t6_grant_after_gap", gp, 1'b1);
        end
        rp = 0;
        tick(); tick();

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) rp = ~rp;
            if ($urandom_range(0, 9) == 0) rn = ~rn;
            td    = ($urandom_range(0, 7) == 0);
            lb    = ($urandom_range(0, 11) == 0);
            reset = ($urandom_range(0, 399) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
